// File: rtl/xgmii_tx_engine_if.sv
// Read port of the XGMII-TX FIFO (first-word-fall-through) as seen by the TX engine.
interface xgmii_tx_engine_if;
  logic [71:0] dout;
  logic        empty;
  logic        rd_en;

  modport master (input dout, input empty, output rd_en);
  modport slave  (output dout, output empty, input rd_en);
endinterface

// File: rtl/xgmii_tx_engine.sv
// Wraps FIFO payload packets in Ethernet/IPv4/UDP + magic word and an 802.3 FCS,
// driving a registered 64-bit XGMII transmit bus.
`ifndef MAGIC_CODE
`define MAGIC_CODE 32'hC0FFEE01
`endif

module xgmii_tx_engine #(
  parameter logic [31:0] MAGIC     = `MAGIC_CODE,
  parameter logic [15:0] UDP_PORT  = 16'd3422,
  parameter int unsigned MAX_WORDS = 180,
  parameter int unsigned IFG_WORDS = 2
) (
  input  logic               xgmii_clk,
  input  logic               sys_rst,
  input  logic [31:0]        if_v4addr,
  input  logic [47:0]        if_macaddr,
  input  logic [31:0]        dest_v4addr,
  input  logic [47:0]        dest_macaddr,
  xgmii_tx_engine_if.master  fifo,
  output logic [63:0]        xgmii_txd,
  output logic [7:0]         xgmii_txc,
  output logic [7:0]         xgmii_pktcount,
  output logic [7:0]         drop_count,
  output logic [7:0]         underrun_count
);

  localparam logic [63:0] IDLE_W = 64'h0707070707070707;
  localparam logic [63:0] PRE_W  = 64'hD5555555555555FB;
  localparam logic [63:0] ERR_W  = 64'h07070707070707FE;
  localparam logic [7:0]  MAX_N  = 8'(MAX_WORDS);
  localparam logic [7:0]  IFG_N  = 8'(IFG_WORDS);

  typedef enum logic [3:0] {
    S_IDLE, S_PREP, S_PRE, S_HDR, S_PAY, S_FCS, S_IFG, S_DRAIN, S_DROP
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, n_q, n_d;
  logic [47:0] smac_q, smac_d, dmac_q, dmac_d;
  logic [31:0] sip_q, sip_d, dip_q, dip_d;
  logic [15:0] csum_q, csum_d, id_q, id_d;
  logic [31:0] crc_q, crc_d;
  logic [63:0] txd_q, txd_d;
  logic [7:0]  txc_q, txc_d;
  logic [7:0]  pkt_q, pkt_d, drop_q, drop_d, under_q, under_d;
  logic        rd_en_d;

  logic [7:0]   n_head, plen;
  logic [15:0]  ip_len, udp_len;
  logic [383:0] hdr, hdr_sh;
  logic [63:0]  hdr_word;
  logic [19:0]  cs_sum;
  logic [16:0]  cs_f1;
  logic [15:0]  cs_f2;

  // Reflected CRC-32, bits consumed LSB-first starting at lane 0
  function automatic logic [31:0] crc64(input logic [31:0] c, input logic [63:0] d);
    logic [31:0] r;
    r = c;
    for (int unsigned i = 0; i < 64; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign n_head  = fifo.dout[71:64];
  assign plen    = (n_q < 8'd2) ? 8'd2 : n_q;
  assign ip_len  = 16'd34 + {5'd0, plen, 3'd0};
  assign udp_len = 16'd14 + {5'd0, plen, 3'd0};

  assign hdr = {dmac_q, smac_q, 16'h0800, 16'h4500, ip_len, id_q, 16'h4000, 16'h4011,
                csum_q, sip_q, dip_q, UDP_PORT, UDP_PORT, udp_len, 16'h0000, MAGIC, 16'h0000};
  // Header is held big-endian; shift the wanted word to the top, then byte-swap into lanes
  assign hdr_sh   = hdr << {cnt_q[2:0], 6'd0};
  assign hdr_word = {<<8{hdr_sh[383:320]}};

  assign cs_sum = 20'h04500 + 20'(ip_len) + 20'(id_q) + 20'h04000 + 20'h04011
                + 20'(sip_q[31:16]) + 20'(sip_q[15:0]) + 20'(dip_q[31:16]) + 20'(dip_q[15:0]);
  assign cs_f1  = 17'(cs_sum[15:0]) + 17'(cs_sum[19:16]);
  assign cs_f2  = cs_f1[15:0] + 16'(cs_f1[16]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    smac_d  = smac_q;
    dmac_d  = dmac_q;
    sip_d   = sip_q;
    dip_d   = dip_q;
    csum_d  = csum_q;
    id_d    = id_q;
    crc_d   = crc_q;
    pkt_d   = pkt_q;
    drop_d  = drop_q;
    under_d = under_q;
    txd_d   = IDLE_W;
    txc_d   = 8'hFF;
    rd_en_d = 1'b0;
    unique case (state_q)
      S_IDLE: if (!fifo.empty) begin
        if (n_head == 8'd0) begin
          rd_en_d = 1'b1;
          drop_d  = drop_q + 8'd1;
        end else if (n_head > MAX_N) begin
          n_d     = n_head;
          cnt_d   = n_head;
          drop_d  = drop_q + 8'd1;
          state_d = S_DROP;
        end else begin
          n_d     = n_head;
          cnt_d   = '0;
          state_d = S_PREP;
        end
      end
      S_PREP: if (cnt_q == 8'd0) begin
        smac_d = if_macaddr;
        dmac_d = dest_macaddr;
        sip_d  = if_v4addr;
        dip_d  = dest_v4addr;
        cnt_d  = 8'd1;
      end else begin
        csum_d  = ~cs_f2;
        state_d = S_PRE;
      end
      S_PRE: begin
        txd_d   = PRE_W;
        txc_d   = 8'h01;
        crc_d   = '1;
        cnt_d   = '0;
        state_d = S_HDR;
      end
      S_HDR: begin
        txd_d = hdr_word;
        txc_d = '0;
        crc_d = crc64(crc_q, hdr_word);
        if (cnt_q == 8'd5) begin
          cnt_d   = '0;
          state_d = S_PAY;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_PAY: begin
        if (cnt_q < n_q && fifo.empty) begin
          txd_d   = ERR_W;
          under_d = under_q + 8'd1;
          cnt_d   = n_q - cnt_q;
          state_d = S_DRAIN;
        end else begin
          txc_d = '0;
          if (cnt_q < n_q) begin
            rd_en_d = 1'b1;
            txd_d   = fifo.dout[63:0];
          end else begin
            txd_d = '0;
          end
          crc_d = crc64(crc_q, txd_d);
          if (cnt_q == plen - 8'd1) begin
            cnt_d   = '0;
            state_d = S_FCS;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_FCS: begin
        txd_d   = {24'h070707, 8'hFD, ~crc_q};
        txc_d   = 8'hF0;
        pkt_d   = pkt_q + 8'd1;
        id_d    = id_q + 16'd1;
        cnt_d   = '0;
        state_d = S_IFG;
      end
      S_IFG: begin
        if (cnt_q >= IFG_N - 8'd1) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DRAIN, S_DROP: if (!fifo.empty) begin
        rd_en_d = 1'b1;
        cnt_d   = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = (state_q == S_DRAIN) ? S_IFG : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge xgmii_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      smac_q  <= '0;
      dmac_q  <= '0;
      sip_q   <= '0;
      dip_q   <= '0;
      csum_q  <= '0;
      id_q    <= '0;
      crc_q   <= '1;
      txd_q   <= IDLE_W;
      txc_q   <= '1;
      pkt_q   <= '0;
      drop_q  <= '0;
      under_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      smac_q  <= smac_d;
      dmac_q  <= dmac_d;
      sip_q   <= sip_d;
      dip_q   <= dip_d;
      csum_q  <= csum_d;
      id_q    <= id_d;
      crc_q   <= crc_d;
      txd_q   <= txd_d;
      txc_q   <= txc_d;
      pkt_q   <= pkt_d;
      drop_q  <= drop_d;
      under_q <= under_d;
    end
  end

  assign fifo.rd_en     = rd_en_d;
  assign xgmii_txd      = txd_q;
  assign xgmii_txc      = txc_q;
  assign xgmii_pktcount = pkt_q;
  assign drop_count     = drop_q;
  assign underrun_count = under_q;

endmodule

// File: tb/tb_xgmii_tx_engine.sv
// Bench for xgmii_tx_engine: FIFO model, byte-level frame model feeding a scoreboard
// of expected non-idle XGMII words, plus counter and field checks per test vector.
module tb_xgmii_tx_engine;
  localparam logic [31:0] MAGIC  = 32'hC0FFEE01;
  localparam logic [15:0] PORT   = 16'd3422;
  localparam logic [63:0] IDLE_W = 64'h0707070707070707;
  localparam logic [63:0] PRE_W  = 64'hD5555555555555FB;
  localparam logic [63:0] ERR_W  = 64'h07070707070707FE;

  typedef struct { logic [63:0] d; logic [7:0] c; } xw_t;
  typedef struct {
    int unsigned n; int unsigned avail; bit pair; bit zfirst; logic [7:0] base;
    logic [7:0] epkt; logic [7:0] edrop; logic [7:0] eunder;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] sip, dip;
  logic [47:0] smac, dmac;
  logic [63:0] txd;
  logic [7:0]  txc, pktc, dropc, underc;

  xgmii_tx_engine_if fif ();

  xgmii_tx_engine #(.MAGIC(MAGIC), .UDP_PORT(PORT), .MAX_WORDS(180), .IFG_WORDS(2)) dut (
    .xgmii_clk(clk), .sys_rst(rst), .if_v4addr(sip), .if_macaddr(smac),
    .dest_v4addr(dip), .dest_macaddr(dmac), .fifo(fif), .xgmii_txd(txd), .xgmii_txc(txc),
    .xgmii_pktcount(pktc), .drop_count(dropc), .underrun_count(underc));

  always #5 clk = ~clk;

  int unsigned checks = 0, errors = 0;
  logic [71:0] fq[$];
  xw_t         exp_q[$];
  int unsigned push_cnt = 0, pop_cnt = 0;
  logic [63:0] cap [0:199];
  int unsigned widx = 0, gap_cnt = 0, gap_last = 0, frame_len = 0;
  bit          mon_en = 1'b0;
  logic        pop_p;
  logic [71:0] popped;
  xw_t         mon_e;
  logic [15:0] exp_id = '0;
  logic [7:0]  fb [0:1599];
  vec_t        vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic refresh();
    fif.empty = (fq.size() == 0);
    fif.dout  = (fq.size() == 0) ? 72'h0 : fq[0];
  endtask

  // FIFO model: pop decided from rd_en sampled mid-cycle, applied just after the edge
  initial begin
    forever begin
      @(negedge clk);
      pop_p = fif.rd_en;
      if (pop_p === 1'b1) chk("rd_en_while_empty", 64'(fif.empty), 64'd0);
      @(posedge clk);
      #1;
      if (pop_p === 1'b1 && fq.size() != 0) begin
        popped = fq.pop_front();
        pop_cnt++;
        refresh();
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (txd === IDLE_W && txc === 8'hFF) begin
        gap_cnt++;
      end else begin
        if (txc === 8'h01) begin
          gap_last = gap_cnt;
          widx     = 0;
        end
        gap_cnt = 0;
        if (widx < 200) cap[widx] = txd;
        widx++;
        if (txc === 8'hF0) frame_len = widx;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: actual %h/%h required idle", txd, txc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("txd", txd, mon_e.d);
          chk("txc", 64'(txc), 64'(mon_e.c));
        end
      end
    end
  end

  task automatic push_packet(input int unsigned n, input int unsigned cnt, input logic [7:0] base,
                             input int unsigned kstart);
    logic [63:0] d;
    for (int unsigned k = kstart; k < kstart + cnt; k++) begin
      d = '0;
      for (int unsigned j = 0; j < 8; j++) d = (d >> 8) | ({56'h0, 8'(base + 8 * k + j)} << 56);
      fq.push_back({(k == 0) ? 8'(n) : 8'hEE, d});
      push_cnt++;
    end
    refresh();
  endtask

  task automatic gen_frame(input int unsigned n, input int unsigned avail, input logic [7:0] base,
                           input logic [15:0] id);
    int unsigned plen, len, nw;
    logic [15:0] iplen, ulen;
    logic [31:0] sum, crc;
    logic [63:0] w;
    xw_t x;
    plen  = (n < 2) ? 2 : n;
    iplen = 16'(34 + 8 * plen);
    ulen  = 16'(14 + 8 * plen);
    for (int j = 0; j < 6; j++) begin
      fb[j]     = 8'(dmac >> (40 - 8 * j));
      fb[6 + j] = 8'(smac >> (40 - 8 * j));
    end
    fb[12] = 8'h08; fb[13] = 8'h00; fb[14] = 8'h45; fb[15] = 8'h00;
    fb[16] = iplen[15:8]; fb[17] = iplen[7:0]; fb[18] = id[15:8]; fb[19] = id[7:0];
    fb[20] = 8'h40; fb[21] = 8'h00; fb[22] = 8'h40; fb[23] = 8'h11; fb[24] = 8'h00; fb[25] = 8'h00;
    for (int j = 0; j < 4; j++) begin
      fb[26 + j] = 8'(sip >> (24 - 8 * j));
      fb[30 + j] = 8'(dip >> (24 - 8 * j));
      fb[42 + j] = 8'(MAGIC >> (24 - 8 * j));
    end
    fb[34] = PORT[15:8]; fb[35] = PORT[7:0]; fb[36] = PORT[15:8]; fb[37] = PORT[7:0];
    fb[38] = ulen[15:8]; fb[39] = ulen[7:0]; fb[40] = 8'h00; fb[41] = 8'h00;
    fb[46] = 8'h00; fb[47] = 8'h00;
    sum = '0;
    for (int h = 0; h < 10; h++) sum += {16'h0, fb[14 + 2 * h], fb[15 + 2 * h]};
    while ((sum >> 16) != 0) sum = (sum & 32'hFFFF) + (sum >> 16);
    fb[24] = ~sum[15:8];
    fb[25] = ~sum[7:0];
    for (int unsigned k = 0; k < plen; k++)
      for (int unsigned j = 0; j < 8; j++)
        fb[48 + 8 * k + j] = (k < n) ? 8'(base + 8 * k + j) : 8'h00;
    len = 48 + 8 * plen;
    x.d = PRE_W; x.c = 8'h01; exp_q.push_back(x);
    nw = 6 + ((avail < n) ? avail : plen);
    for (int unsigned i = 0; i < nw; i++) begin
      w = '0;
      for (int unsigned j = 0; j < 8; j++) w = (w >> 8) | ({56'h0, fb[8 * i + j]} << 56);
      x.d = w; x.c = 8'h00; exp_q.push_back(x);
    end
    if (avail < n) begin
      x.d = ERR_W; x.c = 8'hFF; exp_q.push_back(x);
    end else begin
      crc = '1;
      for (int unsigned b = 0; b < len; b++) begin
        crc ^= {24'h0, fb[b]};
        for (int unsigned t = 0; t < 8; t++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
      end
      x.d = {24'h070707, 8'hFD, ~crc}; x.c = 8'hF0; exp_q.push_back(x);
    end
  endtask

  task automatic wait_exp(input string name, input int unsigned budget, input bit need_fifo);
    bit done;
    done = 1'b0;
    for (int unsigned i = 0; i < budget && !done; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && (!need_fifo || fq.size() == 0)) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: actual pending=%0d fifo=%0d required 0", name, exp_q.size(), fq.size());
    end
    repeat (10) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    sip  = 32'hC0A80001;
    dip  = 32'hC0A80002;
    smac = 48'h001122334455;
    dmac = 48'h66778899AABB;
    fif.empty = 1'b1;
    fif.dout  = '0;
    //            n    avail pair zf base   pkt drop under
    vecs[0] = '{2,   2,   1'b0, 1'b0, 8'h00, 8'd1, 8'd0, 8'd0};
    vecs[1] = '{1,   1,   1'b0, 1'b0, 8'h40, 8'd2, 8'd0, 8'd0};
    vecs[2] = '{3,   3,   1'b1, 1'b0, 8'h80, 8'd4, 8'd0, 8'd0};
    vecs[3] = '{2,   2,   1'b0, 1'b1, 8'h10, 8'd5, 8'd1, 8'd0};
    vecs[4] = '{200, 200, 1'b0, 1'b0, 8'h20, 8'd5, 8'd2, 8'd0};
    vecs[5] = '{4,   2,   1'b0, 1'b0, 8'h30, 8'd5, 8'd2, 8'd1};
    vecs[6] = '{180, 180, 1'b0, 1'b0, 8'h50, 8'd6, 8'd2, 8'd1};
    vecs[7] = '{181, 181, 1'b0, 1'b0, 8'h60, 8'd6, 8'd3, 8'd1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_txd", txd, IDLE_W);
    chk("reset_txc", 64'(txc), 64'hFF);
    chk("reset_rd_en", 64'(fif.rd_en), 64'd0);
    chk("reset_pktcount", 64'(pktc), 64'd0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    for (int v = 0; v < 8; v++) begin
      if (v == 6) begin
        smac = 48'h0A0B0C0D0E0F;
        dip  = 32'h0A000063;
      end
      if (vecs[v].zfirst) begin
        fq.push_back({8'h00, 64'hDEADBEEF00000000});
        push_cnt++;
        refresh();
      end
      push_packet(vecs[v].n, vecs[v].avail, vecs[v].base, 0);
      if (vecs[v].n >= 1 && vecs[v].n <= 180) begin
        gen_frame(vecs[v].n, vecs[v].avail, vecs[v].base, exp_id);
        if (vecs[v].avail >= vecs[v].n) exp_id++;
      end
      if (vecs[v].pair) begin
        push_packet(vecs[v].n, vecs[v].n, vecs[v].base ^ 8'h80, 0);
        gen_frame(vecs[v].n, vecs[v].n, vecs[v].base ^ 8'h80, exp_id);
        exp_id++;
      end
      wait_exp("frame", 3000, vecs[v].avail >= vecs[v].n);
      if (vecs[v].avail < vecs[v].n) begin
        push_packet(vecs[v].n, vecs[v].n - vecs[v].avail, vecs[v].base, vecs[v].avail);
        wait_exp("drain", 300, 1'b1);
      end
      chk("pktcount", 64'(pktc), 64'(vecs[v].epkt));
      chk("drop_count", 64'(dropc), 64'(vecs[v].edrop));
      chk("underrun_count", 64'(underc), 64'(vecs[v].eunder));
      chk("pops", 64'(pop_cnt), 64'(push_cnt));
      if (v == 0) begin
        chk("frame_words_n2", 64'(frame_len), 64'd10);
        chk("ip_total_len", 64'(cap[3][15:0]), 64'h3200);
        chk("ip_id_first", 64'(cap[3][31:16]), 64'h0000);
        chk("ip_checksum", 64'(cap[4][15:0]), 64'h67B9);
        chk("udp_len", 64'(cap[5][63:48]), 64'h1E00);
      end
      if (v == 1) begin
        chk("frame_words_n1", 64'(frame_len), 64'd10);
        chk("pad_word", cap[8], 64'h0);
        chk("ip_total_len_n1", 64'(cap[3][15:0]), 64'h3200);
      end
      if (v == 2) begin
        chk("b2b_gap", 64'(gap_last), 64'd5);
        chk("ip_id_second", 64'(cap[3][31:16]), 64'h0300);
      end
    end

    // Reset while the header is going out; the packet stays queued and restarts with id 0
    push_packet(2, 2, 8'hA0, 0);
    gen_frame(2, 2, 8'hA0, exp_id);
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
        @(posedge clk);
        #1;
        if (exp_q.size() <= 7) hit = 1'b1;
      end
      chk("reach_hdr", 64'(hit), 64'd1);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_txd", txd, IDLE_W);
    chk("midrst_txc", 64'(txc), 64'hFF);
    chk("midrst_rd_en", 64'(fif.rd_en), 64'd0);
    chk("midrst_pktcount", 64'(pktc), 64'd0);
    chk("midrst_drop", 64'(dropc), 64'd0);
    chk("midrst_under", 64'(underc), 64'd0);
    exp_id = '0;
    gen_frame(2, 2, 8'hA0, exp_id);
    exp_id++;
    wait_exp("after_reset", 500, 1'b1);
    chk("pktcount_after_reset", 64'(pktc), 64'd1);
    chk("ip_id_after_reset", 64'(cap[3][31:16]), 64'h0000);
    chk("pops_after_reset", 64'(pop_cnt), 64'(push_cnt));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xgmii_tx_engine.md
Name: xgmii_tx_engine

Overview:
- Transmit-side counterpart of the XGMII receive engine.
- Pops PCIe-side payload packets from the XGMII-TX FIFO (72-bit, first-word-fall-through).
- Wraps each packet in Ethernet/IPv4/UDP (port 3422) plus the magic code, appends the IEEE 802.3 FCS, and drives a 64-bit XGMII transmit bus.
- Sits between the TX FIFO read port and the 10G PCS/PMA.

Parameters:
MAGIC, 32'h(`MAGIC_CODE), magic word placed at UDP payload bytes 0-3 (big-endian).
UDP_PORT, 16'd3422, UDP source and destination port.
MAX_WORDS, 180, maximum payload words (8 B each) per frame.
IFG_WORDS, 2, idle words forced after each terminate word.

Ports:
xgmii_clk  in  1  single clock; all logic on its rising edge
sys_rst  in  1  synchronous, active-high reset
if_v4addr  in  32  source IPv4 address
if_macaddr  in  48  source MAC address
dest_v4addr  in  32  destination IPv4 address
dest_macaddr  in  48  destination MAC address
dout  in  72  FIFO head word; [63:0] payload, byte0=[7:0] sent first; [71:64] word count N (valid on a packet's first word only)
empty  in  1  FIFO empty
rd_en  out  1  FIFO pop; one word per asserted cycle
xgmii_txd  out  64  XGMII data, lane0=[7:0]
xgmii_txc  out  8  XGMII control, bit i = lane i
xgmii_pktcount  out  8  frames completed, wraps 255->0
drop_count  out  8  packets dropped (N=0 or N>MAX_WORDS), wraps
underrun_count  out  8  frames aborted on FIFO underrun, wraps

Behaviour:
- Reset (also mid-frame): next cycle txd=64'h0707070707070707, txc=8'hFF, rd_en=0, all counters=0, IP id=0, state IDLE.
- Idle word: txd=64'h0707070707070707, txc=8'hFF. Driven in IDLE, PREP, IFG and DROP.

States:
- IDLE: if !empty, latch N=dout[71:64] (FIFO not popped) and go to PREP; else stay.
- N check in IDLE: if N=0, pop 1 word, drop_count++, stay in IDLE. If N>MAX_WORDS, go to DROP.
- DROP: pops N words total, stalling while empty; drop_count++ on entry; then IDLE.
- PREP (exactly 2 cycles):
  - Sample all address inputs; later changes are ignored until the next PREP.
  - Compute the IPv4 header checksum: ones-complement sum of the 10 header halfwords (checksum field=0), carries folded, inverted.
- PRE (1 cycle): txd=64'hD5555555555555FB, txc=8'h01.
- HDR (6 cycles, frame bytes 0-47, txc=0), all fields big-endian:
  - dest_macaddr, if_macaddr, type 0x0800.
  - IPv4: 45 00, total length 34+8*max(N,2), id, 40 00, TTL 0x40, proto 0x11, checksum, src if_v4addr, dst dest_v4addr.
  - UDP: sport UDP_PORT, dport UDP_PORT, length 14+8*max(N,2), checksum 0000.
  - MAGIC, then 2 bytes 00.
- PAY (max(N,2) cycles, txc=0):
  - Word k<N: txd=dout[63:0] with rd_en=1 the same cycle.
  - If N=1, the second word is 64'h0 (minimum 60-byte frame).
  - If empty while a FIFO word is due: txd=64'h07070707070707FE, txc=8'hFF (error), underrun_count++; go to DRAIN.
- DRAIN: pops the packet's remaining words (stall on empty), then IFG.
- FCS (1 cycle):
  - txd={24'h070707, 8'hFD, fcs}, txc=8'hF0.
  - fcs = standard 802.3 CRC-32 over frame bytes 0..end (preamble excluded), least-significant FCS byte in lane 0.
  - xgmii_pktcount++, IP id++ (16-bit wrap).
- IFG: IFG_WORDS idle cycles, then IDLE.
- Back-to-back packets: terminate word, then 5 idle words (2 IFG + 1 IDLE + 2 PREP), then preamble.
- CRC is updated combinationally per 64-bit word; no other pipeline latency. Output registered: the state decision in cycle t appears on txd/txc in cycle t+1.
- rd_en is never asserted while empty. Pops only occur in PAY, DRAIN, DROP and the N=0 path.

Test Plan:
1. Single packet, if_macaddr=00:11:22:33:44:55, dest_macaddr=66:77:88:99:AA:BB, if_v4addr=192.168.0.1, dest_v4addr=192.168.0.2, N=2, payload 64'h0706050403020100 and 64'h0F0E0D0C0B0A0908 -> preamble, 6 header words, 2 payload words, FCS word (10 words total); IP total length 0x0032, UDP length 0x001E, checksum 0xB967, id 0; FCS matches the reference CRC-32; xgmii_pktcount=1.
2. N=1 -> one FIFO pop, zero pad word, IP length 0x0032, 64-byte frame on the wire.
3. Two queued N=3 packets -> exactly 5 idle words between the first FCS word and the second preamble; second frame carries id=1.
4. Head word N=0, then a valid N=2 packet -> drop_count=1, one pop for the dropped word, valid frame follows. N=200 -> 200 pops, nothing transmitted, drop_count increments.
5. N=4 with only 2 words in the FIFO -> error word 64'h07070707070707FE/txc FF after 2 payload words; underrun_count=1; the remaining 2 words are popped once written; no FCS word is sent.
6. sys_rst asserted during HDR -> next cycle idle output, rd_en=0, all counters 0; the next frame uses id 0.
